uart_ram_loader: RTL and testbench

- Host-to-RAM write path: receives a framed byte stream on a UART RX pin and writes 16-bit words into data RAM port B.
- This lets test data and screen images be preloaded while the CPU is held in reset.
- It is the write-side counterpart of the VGA screen reader on port B. Top-level muxes port B address, data and wren to this block while busy is high.

---
 rtl/uart_ram_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
`timescale 1ns/1ps
// uart_ram_loader
//   Receives a framed byte stream on a UART RX line (8N1, idle high) and
//   writes big-endian 16-bit words into data RAM port B.
//   Frame: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {DATA_H, DATA_L} x CNT, CHECK
//   where CHECK is the XOR of every byte between SYNC and CHECK.
//
// Ports
//   CLK_50        system clock (single domain)
//   reset         asynchronous, active-high reset
//   rx            UART serial input, asynchronous to CLK_50
//   ram_address   port B write address (held between writes)
//   ram_data      port B write data (held between writes)
//   ram_we        one-cycle write strobe
//   busy          frame in progress
//   done          last frame finished with a good checksum
//   error         last frame failed (framing or checksum)
//   words_written words written in the current or last frame
module uart_ram_loader #(
  parameter int         CLKS_PER_BIT       = 434,
  parameter int         DATA_WIDTH         = 16,
  parameter int         RAM_REGISTER_COUNT = 1024,
  parameter logic [7:0] SYNC_BYTE          = 8'hA5
) (
  input  logic                                  CLK_50,
  input  logic                                  reset,
  input  logic                                  rx,
  output logic [$clog2(RAM_REGISTER_COUNT)-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]                 ram_data,
  output logic                                  ram_we,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error,
  output logic [15:0]                           words_written
);

  localparam int AW = $clog2(RAM_REGISTER_COUNT);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {
    F_IDLE, F_ADDR_H, F_ADDR_L, F_CNT_H, F_CNT_L, F_DATA_H, F_DATA_L, F_CHECK
  } fr_state_t;

  logic       rx_p0;
  logic       rxs;
  rx_state_t  rx_state, rx_next;
  cnt_t       clk_cnt;
  logic [2:0] bit_idx;
  logic [7:0] rx_shift;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       framing_err;

  fr_state_t  fr_state, fr_next;
  logic [7:0] addr_h;
  logic [7:0] cnt_h;
  logic [7:0] data_h;
  addr_t      base_addr;
  logic [15:0] word_count;
  logic [7:0] checksum;

  // ---- stage p0/p1: rx synchronizer, preset to the idle level ----
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rxs   <= rx_p0;
    end
  end

  // ---- byte receiver ----
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    byte_valid  = 1'b0;
    framing_err = 1'b0;
    case (rx_state)
      R_IDLE:  if (!rxs) rx_next = R_START;
      // mid-start-bit check rejects short low glitches
      R_START: if (clk_cnt == HALF_LAST) rx_next = rxs ? R_IDLE : R_DATA;
      R_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          rx_next = R_IDLE;
          if (rxs) byte_valid  = 1'b1;
          else     framing_err = 1'b1;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        R_START: clk_cnt <= (clk_cnt == HALF_LAST) ? '0 : clk_cnt + 1'b1;
        R_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: clk_cnt <= (clk_cnt == BIT_LAST) ? '0 : clk_cnt + 1'b1;
      endcase
    end
  end

  // LSB arrives first, so shift in from the top
  always_ff @(posedge CLK_50) begin
    if (rx_state == R_DATA && clk_cnt == BIT_LAST) rx_shift <= {rxs, rx_shift[7:1]};
  end

  assign rx_byte = rx_shift;

  // ---- frame parser ----
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) fr_state <= F_IDLE;
    else       fr_state <= fr_next;
  end

  always_comb begin
    fr_next = fr_state;
    if (framing_err && fr_state != F_IDLE) begin
      fr_next = F_IDLE;
    end else if (byte_valid) begin
      case (fr_state)
        F_IDLE:   if (rx_byte == SYNC_BYTE) fr_next = F_ADDR_H;
        F_ADDR_H: fr_next = F_ADDR_L;
        F_ADDR_L: fr_next = F_CNT_H;
        F_CNT_H:  fr_next = F_CNT_L;
        F_CNT_L:  fr_next = ({cnt_h, rx_byte} == 16'd0) ? F_CHECK : F_DATA_H;
        F_DATA_H: fr_next = F_DATA_L;
        F_DATA_L: fr_next = (words_written + 16'd1 == word_count) ? F_CHECK : F_DATA_H;
        F_CHECK:  fr_next = F_IDLE;
        default:  fr_next = F_IDLE;
      endcase
    end
  end

  // Header fields only matter once captured, so they carry no reset
  always_ff @(posedge CLK_50) begin
    if (byte_valid) begin
      case (fr_state)
        F_ADDR_H: addr_h     <= rx_byte;
        F_ADDR_L: base_addr  <= addr_t'({addr_h, rx_byte});
        F_CNT_H:  cnt_h      <= rx_byte;
        F_CNT_L:  word_count <= {cnt_h, rx_byte};
        F_DATA_H: data_h     <= rx_byte;
        default: ;
      endcase
    end
  end

  // ---- stage p2: RAM write port and status ----
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      ram_address   <= '0;
      ram_data      <= '0;
      ram_we        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      checksum      <= '0;
    end else begin
      ram_we <= 1'b0;
      if (framing_err && fr_state != F_IDLE) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end else if (byte_valid) begin
        case (fr_state)
          F_IDLE: begin
            if (rx_byte == SYNC_BYTE) begin
              done          <= 1'b0;
              error         <= 1'b0;
              words_written <= '0;
              checksum      <= '0;
              busy          <= 1'b1;
            end
          end
          F_ADDR_H, F_ADDR_L, F_CNT_H, F_CNT_L, F_DATA_H: begin
            checksum <= checksum ^ rx_byte;
          end
          F_DATA_L: begin
            checksum      <= checksum ^ rx_byte;
            ram_we        <= 1'b1;
            ram_data      <= {data_h, rx_byte};
            // AW-bit sum wraps at the end of the RAM
            ram_address   <= base_addr + addr_t'(words_written);
            words_written <= words_written + 16'd1;
          end
          F_CHECK: begin
            busy <= 1'b0;
            if (rx_byte == checksum) done  <= 1'b1;
            else                     error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
`timescale 1ns/1ps
module tb_uart_ram_loader;

  localparam int CPB  = 8;
  localparam int RAMN = 1024;

  logic        CLK_50 = 1'b0;
  logic        reset  = 1'b1;
  logic        rx     = 1'b1;
  logic [9:0]  ram_address;
  logic [15:0] ram_data;
  logic        ram_we;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  uart_ram_loader #(
    .CLKS_PER_BIT      (CPB),
    .DATA_WIDTH        (16),
    .RAM_REGISTER_COUNT(RAMN),
    .SYNC_BYTE         (8'hA5)
  ) dut (
    .CLK_50       (CLK_50),
    .reset        (reset),
    .rx           (rx),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_we       (ram_we),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  always #5 CLK_50 = ~CLK_50;

  int n_checks = 0;
  int n_err    = 0;

  // every write strobe the DUT issues
  logic [9:0]  wq_a[$];
  logic [15:0] wq_d[$];
  always @(negedge CLK_50) begin
    if (ram_we) begin
      wq_a.push_back(ram_address);
      wq_d.push_back(ram_data);
    end
  end

  logic [15:0] wlist[$];
  logic [7:0]  fq[$];

  typedef struct {
    logic [15:0] base;
    int          cnt;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [7:0]  cx;
    logic        exp_done;
    logic        exp_err;
    int          exp_ww;
    logic [9:0]  exp_a0;
    logic [9:0]  exp_a1;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_addr"}, 32'(ram_address), 0);
    chk({nm, "_data"}, 32'(ram_data), 0);
    chk({nm, "_we"}, 32'(ram_we), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_error"}, 32'(error), 0);
    chk({nm, "_ww"}, 32'(words_written), 0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge CLK_50);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge CLK_50);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_ok;
    idle(CPB);
    rx = 1'b1;
    idle(2);
  endtask

  // SYNC, address, count, words (big-endian), XOR checksum optionally corrupted by cx
  task automatic build_frame(input logic [15:0] base, input logic [7:0] cx);
    logic [7:0]  cs;
    logic [15:0] cnt;
    cnt = 16'(wlist.size());
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(base[15:8]);
    fq.push_back(base[7:0]);
    fq.push_back(cnt[15:8]);
    fq.push_back(cnt[7:0]);
    foreach (wlist[i]) begin
      fq.push_back(wlist[i][15:8]);
      fq.push_back(wlist[i][7:0]);
    end
    cs = 8'h00;
    for (int i = 1; i < fq.size(); i++) cs = cs ^ fq[i];
    fq.push_back(cs ^ cx);
  endtask

  task automatic send_frame(input string nm, input bit chk_busy);
    foreach (fq[i]) begin
      send_byte(fq[i], 1'b1);
      if (chk_busy && i == 0) chk({nm, "_busy_after_sync"}, 32'(busy), 1);
    end
    idle(4);
  endtask

  // reference: word i lands at (base mod depth + i) mod depth
  task automatic check_model(input string nm, input logic [15:0] base, input bit good);
    int n;
    int ea;
    n = wlist.size();
    chk({nm, "_nwrites"}, 32'(wq_a.size()), 32'(n));
    for (int i = 0; i < n && i < wq_a.size(); i++) begin
      ea = ((int'(base) % RAMN) + i) % RAMN;
      chk($sformatf("%s_addr%0d", nm, i), 32'(wq_a[i]), 32'(ea));
      chk($sformatf("%s_data%0d", nm, i), 32'(wq_d[i]), 32'(wlist[i]));
    end
    chk({nm, "_done"}, 32'(done), 32'(good));
    chk({nm, "_error"}, 32'(!good), 32'(error) ^ 32'(0)) ;
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_ww"}, 32'(words_written), 32'(n));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb;
    int          rc;
    bit          good;

    vt[0] = '{16'h0010, 2, 16'h1234, 16'hABCD, 8'h00, 1'b1, 1'b0, 2, 10'h010, 10'h011};
    vt[1] = '{16'h0010, 2, 16'h1234, 16'hABCD, 8'h01, 1'b0, 1'b1, 2, 10'h010, 10'h011};
    vt[2] = '{16'h03FF, 2, 16'h0001, 16'h0002, 8'h00, 1'b1, 1'b0, 2, 10'h3FF, 10'h000};
    vt[3] = '{16'h0005, 0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 0, 10'h000, 10'h000};
    vt[4] = '{16'h1403, 1, 16'hBEEF, 16'h0000, 8'h00, 1'b1, 1'b0, 1, 10'h003, 10'h000};

    idle(3);
    check_zero("reset");
    reset = 1'b0;
    idle(5);

    // table-driven frames
    for (int k = 0; k < 5; k++) begin
      wlist.delete();
      if (vt[k].cnt > 0) wlist.push_back(vt[k].d0);
      if (vt[k].cnt > 1) wlist.push_back(vt[k].d1);
      build_frame(vt[k].base, vt[k].cx);
      wq_a.delete();
      wq_d.delete();
      send_frame($sformatf("vec%0d", k), 1'b1);
      chk($sformatf("vec%0d_nwrites", k), 32'(wq_a.size()), 32'(vt[k].cnt));
      if (vt[k].cnt > 0 && wq_a.size() > 0) begin
        chk($sformatf("vec%0d_a0", k), 32'(wq_a[0]), 32'(vt[k].exp_a0));
        chk($sformatf("vec%0d_d0", k), 32'(wq_d[0]), 32'(vt[k].d0));
      end
      if (vt[k].cnt > 1 && wq_a.size() > 1) begin
        chk($sformatf("vec%0d_a1", k), 32'(wq_a[1]), 32'(vt[k].exp_a1));
        chk($sformatf("vec%0d_d1", k), 32'(wq_d[1]), 32'(vt[k].d1));
      end
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(vt[k].exp_done));
      chk($sformatf("vec%0d_error", k), 32'(error), 32'(vt[k].exp_err));
      chk($sformatf("vec%0d_busy", k), 32'(busy), 0);
      chk($sformatf("vec%0d_ww", k), 32'(words_written), 32'(vt[k].exp_ww));
    end

    // bad stop bit on the low byte of the first word
    wlist.delete();
    wlist.push_back(16'h1234);
    wlist.push_back(16'hABCD);
    build_frame(16'h0010, 8'h00);
    wq_a.delete();
    wq_d.delete();
    for (int i = 0; i < 6; i++) send_byte(fq[i], 1'b1);
    send_byte(fq[6], 1'b0);
    idle(12 * CPB);
    chk("ferr_nwrites", 32'(wq_a.size()), 0);
    chk("ferr_error", 32'(error), 1);
    chk("ferr_done", 32'(done), 0);
    chk("ferr_busy", 32'(busy), 0);
    chk("ferr_ww", 32'(words_written), 0);
    wq_a.delete();
    wq_d.delete();
    send_frame("after_ferr", 1'b0);
    check_model("after_ferr", 16'h0010, 1'b1);

    // short low glitch between bytes, and a SYNC value inside the data
    wlist.delete();
    wlist.push_back(16'hA5A5);
    build_frame(16'h0200, 8'h00);
    wq_a.delete();
    wq_d.delete();
    send_byte(fq[0], 1'b1);
    send_byte(fq[1], 1'b1);
    @(negedge CLK_50);
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(3 * CPB);
    chk("glitch_busy", 32'(busy), 1);
    for (int i = 2; i < fq.size(); i++) send_byte(fq[i], 1'b1);
    idle(4);
    check_model("glitch", 16'h0200, 1'b1);

    // reset in the middle of a data byte
    wlist.delete();
    wlist.push_back(16'h1234);
    build_frame(16'h0010, 8'h00);
    wq_a.delete();
    wq_d.delete();
    for (int i = 0; i < 6; i++) send_byte(fq[i], 1'b1);
    @(negedge CLK_50);
    rx = 1'b0;
    idle(CPB);
    rx = 1'b0;
    idle(2 * CPB);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    rx = 1'b1;
    idle(5);
    reset = 1'b0;
    idle(12 * CPB);
    chk("midrst_nwrites", 32'(wq_a.size()), 0);
    chk("midrst_busy", 32'(busy), 0);
    send_frame("post_rst", 1'b0);
    check_model("post_rst", 16'h0010, 1'b1);

    // randomized frames against the reference
    for (int f = 0; f < 16; f++) begin
      rb = 16'($urandom);
      rc = $urandom_range(0, 4);
      good = ($urandom_range(0, 3) != 0);
      wlist.delete();
      for (int i = 0; i < rc; i++) wlist.push_back(16'($urandom));
      build_frame(rb, good ? 8'h00 : 8'($urandom_range(1, 255)));
      wq_a.delete();
      wq_d.delete();
      send_frame($sformatf("rnd%0d", f), 1'b0);
      check_model($sformatf("rnd%0d", f), rb, good);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
